fan_pwm_ctrl: RTL

- Downstream consumer of the ALU adder stage in the fan speed controller.
- Accepts an adder result (Sum plus Cout) over a valid/ready handshake and saturates it into a target duty.
- Ramps the applied duty toward the target in fixed steps, one step per PWM period.
- Drives a glitch-free PWM output to the fan driver.

---
 rtl/fan_ctrl_pkg.sv | 14 +
 rtl/pwm_period_timer.sv | 48 ++++
 rtl/fan_pwm_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fan_ctrl_pkg.sv
// Shared types and constants for the fan PWM controller.
// Holds the ramp FSM state encoding and the default duty width and full-scale value.
package fan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;

    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] DUTY_FULL = '1;

endpackage

// File: rtl/pwm_period_timer.sv
// PWM period timebase: a prescaler feeding a counter that runs over 0..2^N-2.
// Produces tick, the period boundary strobe, and a registered period_start pulse.
module pwm_period_timer
    import fan_ctrl_pkg::*;
#(
    parameter int N        = DUTY_W,
    parameter int PRESCALE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    output logic [N-1:0] cnt,
    output logic         tick,
    output logic         boundary,
    output logic         period_start
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [N-1:0]    CNT_LAST = {{(N-1){1'b1}}, 1'b0};

    logic [PS_W-1:0] prescaler;

    // Timebase is frozen at zero while disabled, so no boundary can fire then.
    assign tick     = enable && (prescaler == PS_LAST);
    assign boundary = tick && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler    <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            if (!enable) begin
                prescaler <= '0;
                cnt       <= '0;
            end else begin
                prescaler <= tick ? '0 : prescaler + PS_W'(1);
                if (boundary)
                    cnt <= '0;
                else if (tick)
                    cnt <= cnt + N'(1);
            end
        end
    end

endmodule

// File: rtl/fan_pwm_ctrl.sv
// Fan PWM controller: accepts saturated adder results as a target duty, ramps the
// applied duty toward it one step per PWM period, and drives a registered PWM output.
module fan_pwm_ctrl
    import fan_ctrl_pkg::*;
#(
    parameter int N         = DUTY_W,
    parameter int RAMP_STEP = 4,
    parameter int PRESCALE  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sum_in,
    input  logic         cout_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         enable,
    output logic         pwm_out,
    output logic [N-1:0] duty_cur,
    output logic         period_start,
    output logic         busy,
    output logic         sat_flag
);

    localparam logic [N-1:0] STEP = N'(RAMP_STEP);

    // Adder overflow clamps to full-scale duty.
    function automatic logic [N-1:0] sat_result(input logic [N-1:0] sum, input logic cout);
        return cout ? {N{1'b1}} : sum;
    endfunction

    function automatic logic [N-1:0] step_toward(input logic [N-1:0] cur, input logic [N-1:0] tgt);
        logic [N:0] up;
        up = {1'b0, cur} + {1'b0, STEP};
        if (cur < tgt)
            return (up > {1'b0, tgt}) ? tgt : up[N-1:0];
        else if (cur > tgt)
            return ((cur - tgt) <= STEP) ? tgt : cur - STEP;
        else
            return cur;
    endfunction

    logic [N-1:0] cnt;
    logic         tick;
    logic         boundary;
    logic [N-1:0] target;
    logic [N-1:0] pend_val;
    logic         pend;
    ramp_state_t  state;
    logic         accept;
    logic [N-1:0] duty_step;
    logic [N-1:0] duty_next;
    logic [N-1:0] cnt_next;

    pwm_period_timer #(
        .N        (N),
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cnt          (cnt),
        .tick         (tick),
        .boundary     (boundary),
        .period_start (period_start)
    );

    assign in_ready  = !pend;
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE) || (enable && (duty_cur != target));
    assign duty_step = step_toward(duty_cur, target);

    // Compare against next-cycle values so pwm_out lines up with cnt and duty_cur.
    always_comb begin
        duty_next = duty_cur;
        cnt_next  = cnt;
        if (!enable) begin
            duty_next = '0;
            cnt_next  = '0;
        end else if (boundary) begin
            duty_next = duty_step;
            cnt_next  = '0;
        end else if (tick) begin
            cnt_next  = cnt + N'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out  <= 1'b0;
            duty_cur <= '0;
            target   <= '0;
            pend     <= 1'b0;
            sat_flag <= 1'b0;
            state    <= IDLE;
        end else begin
            pwm_out  <= enable && (cnt_next < duty_next);
            duty_cur <= duty_next;
            if (!enable) begin
                state <= IDLE;
                // A held transfer flushes first; otherwise accepts go straight to target.
                if (pend) begin
                    target <= pend_val;
                    pend   <= 1'b0;
                end else if (accept) begin
                    target   <= sat_result(sum_in, cout_in);
                    sat_flag <= cout_in;
                end
            end else begin
                if (boundary) begin
                    if (duty_step == target)
                        state <= IDLE;
                    else if (duty_cur < target)
                        state <= RAMP_UP;
                    else
                        state <= RAMP_DOWN;
                    if (pend) begin
                        target <= pend_val;
                        pend   <= 1'b0;
                    end
                end
                if (accept) begin
                    pend     <= 1'b1;
                    sat_flag <= cout_in;
                end
            end
        end
    end

    // Pending value is pure data and only read while pend is set.
    always_ff @(posedge clk) begin
        if (accept && enable)
            pend_val <= sat_result(sum_in, cout_in);
    end

endmodule
